adau1761_spi_sequencer: RTL

Owns the ADAU1761 SPI control port. After reset it enters SPI mode with three dummy frames, then writes a fixed init table. It then serves single register read/write requests from a host port, one frame at a time. It replaces free-running configuration with a clocked, divided SPI master that host control logic (e.g. the volume/mute controller) shares with the boot sequence; init has absolute priority.

---
 rtl/adau1761_spi_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/adau1761_spi_sequencer.sv
// rtl/adau1761_spi_sequencer.sv - ADAU1761 SPI control-port master with boot sequence and host register access
//
// Purpose: after reset, sends three dummy frames to latch SPI mode, then a fixed
// four-entry init table, then serves single host register reads/writes.
// Each frame is 32 bits MSB first: {7'b0, rw}, addr[15:8], addr[7:0], data.
//
// Ports:
//   clk, resetn           system clock, synchronous active-low reset
//   req_valid/req_ready   host request handshake (ready is high only in IDLE)
//   req_rw/addr/wdata     host request fields (rw: 1 = read)
//   rsp_valid/rsp_rdata   one-cycle response pulse per host frame, read data
//   init_done             boot sequence complete
//   sclk, cs, sdo, sdi    SPI pins (sclk idles high, cs active low)
module adau1761_spi_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        init_done,
    output logic        sclk,
    output logic        cs,
    output logic        sdo,
    input  logic        sdi
);

    localparam logic [1:0] SEQ_DUMMY = 2'd0;
    localparam logic [1:0] SEQ_INIT  = 2'd1;
    localparam logic [1:0] SEQ_IDLE  = 2'd2;
    localparam logic [1:0] SEQ_HOST  = 2'd3;

    localparam logic [1:0] ENG_SETUP = 2'd0;
    localparam logic [1:0] ENG_SHIFT = 2'd1;
    localparam logic [1:0] ENG_HOLD  = 2'd2;
    localparam logic [1:0] ENG_GAP   = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    logic [1:0]  seq_state;
    logic [2:0]  seq_idx;
    logic [1:0]  eng_state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [30:0] shift_reg;
    logic [7:0]  rx_reg;
    logic        host_rw;
    logic        host_pending;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;

    logic        gap_done;
    logic        frame_end;
    logic        start_frame;
    logic [31:0] frame_word;
    logic [31:0] init_word;

    always_comb begin
        init_word = 32'h0040_0001;
        case (seq_idx[1:0])
            2'd0:    init_word = 32'h0040_0001;
            2'd1:    init_word = 32'h0040_1501;
            2'd2:    init_word = 32'h0040_F97F;
            default: init_word = 32'h0040_FA03;
        endcase
    end

    // The engine parks in GAP with the counter at zero; that is the "free" condition.
    always_comb begin
        gap_done    = (eng_state == ENG_GAP) && (div_cnt == 8'd0);
        frame_end   = (eng_state == ENG_HOLD) && (div_cnt == 8'd0);
        start_frame = 1'b0;
        frame_word  = 32'h0040_0000;
        case (seq_state)
            SEQ_DUMMY: start_frame = gap_done;
            SEQ_INIT: begin
                start_frame = gap_done && (seq_idx != 3'd4);
                frame_word  = init_word;
            end
            SEQ_HOST: begin
                start_frame = host_pending;
                frame_word  = {7'b0, host_rw, host_addr, host_rw ? 8'h00 : host_wdata};
            end
            default: ;
        endcase
    end

    // Sequencer: boot ordering, host handshake, response generation.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            seq_state    <= SEQ_DUMMY;
            seq_idx      <= 3'd0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 8'h00;
            init_done    <= 1'b0;
            host_rw      <= 1'b0;
            host_addr    <= 16'h0000;
            host_wdata   <= 8'h00;
            host_pending <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (seq_state)
                SEQ_DUMMY: begin
                    if (gap_done) begin
                        if (seq_idx == 3'd2) begin
                            seq_state <= SEQ_INIT;
                            seq_idx   <= 3'd0;
                        end else begin
                            seq_idx <= seq_idx + 3'd1;
                        end
                    end
                end
                SEQ_INIT: begin
                    // seq_idx reaches 4 once the last table entry has been launched.
                    if (frame_end && seq_idx == 3'd4) begin
                        init_done <= 1'b1;
                    end
                    if (gap_done) begin
                        if (seq_idx == 3'd4) begin
                            seq_state <= SEQ_IDLE;
                            req_ready <= 1'b1;
                        end else begin
                            seq_idx <= seq_idx + 3'd1;
                        end
                    end
                end
                SEQ_IDLE: begin
                    if (req_valid && req_ready) begin
                        host_rw      <= req_rw;
                        host_addr    <= req_addr;
                        host_wdata   <= req_wdata;
                        host_pending <= 1'b1;
                        req_ready    <= 1'b0;
                        seq_state    <= SEQ_HOST;
                    end
                end
                default: begin
                    // The engine is already free here, so the frame launches the cycle after acceptance.
                    if (host_pending) begin
                        host_pending <= 1'b0;
                    end
                    if (frame_end) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= host_rw ? rx_reg : 8'h00;
                    end else if (gap_done && !host_pending) begin
                        seq_state <= SEQ_IDLE;
                        req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Frame engine: SETUP (D) + 32 x (low D, high D) + HOLD (D) = 66*D cycles with cs low.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            eng_state <= ENG_GAP;
            div_cnt   <= 8'd0;
            bit_cnt   <= 5'd0;
            shift_reg <= 31'd0;
            rx_reg    <= 8'h00;
            cs        <= 1'b1;
            sclk      <= 1'b1;
            sdo       <= 1'b0;
        end else begin
            case (eng_state)
                ENG_GAP: begin
                    if (start_frame) begin
                        shift_reg <= frame_word[30:0];
                        sdo       <= frame_word[31];
                        cs        <= 1'b0;
                        sclk      <= 1'b1;
                        div_cnt   <= DIV_LAST;
                        eng_state <= ENG_SETUP;
                    end else if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                ENG_SETUP: begin
                    if (div_cnt == 8'd0) begin
                        // First falling edge keeps bit31, which was set up with cs.
                        sclk      <= 1'b0;
                        bit_cnt   <= 5'd0;
                        div_cnt   <= DIV_LAST;
                        eng_state <= ENG_SHIFT;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                ENG_SHIFT: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (!sclk) begin
                        sclk    <= 1'b1;
                        rx_reg  <= {rx_reg[6:0], sdi};
                        div_cnt <= DIV_LAST;
                    end else if (bit_cnt == 5'd31) begin
                        div_cnt   <= DIV_LAST;
                        eng_state <= ENG_HOLD;
                    end else begin
                        sclk      <= 1'b0;
                        sdo       <= shift_reg[30];
                        shift_reg <= {shift_reg[29:0], 1'b0};
                        bit_cnt   <= bit_cnt + 5'd1;
                        div_cnt   <= DIV_LAST;
                    end
                end
                default: begin
                    if (div_cnt == 8'd0) begin
                        cs        <= 1'b1;
                        sdo       <= 1'b0;
                        div_cnt   <= GAP_LAST;
                        eng_state <= ENG_GAP;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
